// File: rtl/vga_scanout.sv
// VGA raster scan-out: walks an h/v raster, fetches pixels linearly from a 1-clock-latency
// framebuffer and emits pixel, syncs and flags aligned 3 clocks after the counter state.
// Optional colour-bar source enabled by defining VGA_SCANOUT_TEST_PATTERN_EN.
module vga_scanout #(
    parameter int BITS_PER_PIXEL = 3,
    parameter int H_VISIBLE      = 640,
    parameter int H_FRONT        = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BACK         = 48,
    parameter int V_VISIBLE      = 480,
    parameter int V_FRONT        = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 33
) (
    input  logic                                       i_Clock,
    input  logic                                       i_Reset,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    input  logic                                       i_Test_Pattern,
`endif
    output logic [$clog2(H_VISIBLE*V_VISIBLE-1):0]     o_Read_Addr,
    input  logic [BITS_PER_PIXEL-1:0]                  i_Read_Data,
    output logic [BITS_PER_PIXEL-1:0]                  o_Pixel,
    output logic                                       o_HSync,
    output logic                                       o_VSync,
    output logic                                       o_Active,
    output logic                                       o_Frame_Start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    // h keeps at least 9 bits so the colour-bar tap h[8:6] always exists
    localparam int HW = ($clog2(H_TOTAL) > 9) ? $clog2(H_TOTAL) : 9;
    localparam int VW = ($clog2(V_TOTAL) > 1) ? $clog2(V_TOTAL) : 1;
    localparam int AW = $clog2(H_VISIBLE*V_VISIBLE-1) + 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SS     = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SE     = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SS     = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SE     = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [HW-1:0]             h_q, h_d;
    logic [VW-1:0]             v_q, v_d;
    logic [AW-1:0]             addr_cnt_q, addr_cnt_d;
    logic [AW-1:0]             rd_addr_q, rd_addr_d;
    logic                      h_wrap_s, v_wrap_s;
    logic                      vis_s, hs_s, vs_s, fs_s;
    logic [1:0]                vis_pipe_q, hs_pipe_q, vs_pipe_q, fs_pipe_q;
    logic [BITS_PER_PIXEL-1:0] pixel_src_s, pixel_d, pixel_q;
    logic                      hsync_n_q, vsync_n_q, active_q, frame_start_q;

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    logic [2:0] bar1_q, bar2_q;

    function automatic logic [BITS_PER_PIXEL-1:0] bar_to_pixel(input logic [2:0] bar);
        logic [BITS_PER_PIXEL+2:0] ext;
        ext = {{BITS_PER_PIXEL{1'b0}}, bar};
        return ext[BITS_PER_PIXEL-1:0];
    endfunction
`endif

    // Raster position, decoded flags and the linear address counter next state
    always_comb begin
        h_wrap_s = (h_q == H_LAST);
        v_wrap_s = (v_q == V_LAST);
        vis_s    = (h_q < H_VIS) && (v_q < V_VIS);
        hs_s     = (h_q >= H_SS) && (h_q < H_SE);
        vs_s     = (v_q >= V_SS) && (v_q < V_SE);
        fs_s     = (h_q == {HW{1'b0}}) && (v_q == {VW{1'b0}});
        if (h_wrap_s) begin
            h_d = {HW{1'b0}};
            if (v_wrap_s) begin
                v_d = {VW{1'b0}};
            end else begin
                v_d = v_q + VW'(1);
            end
        end else begin
            h_d = h_q + HW'(1);
            v_d = v_q;
        end
        // Counter tracks the index of the current visible pixel; idle through blanking
        if (h_wrap_s && v_wrap_s) begin
            addr_cnt_d = {AW{1'b0}};
        end else if (vis_s) begin
            addr_cnt_d = addr_cnt_q + AW'(1);
        end else begin
            addr_cnt_d = addr_cnt_q;
        end
        if (vis_s) begin
            rd_addr_d = addr_cnt_q;
        end else begin
            rd_addr_d = rd_addr_q;
        end
    end

    // Output pixel selection with blanking applied from the stage-2 visible flag
    always_comb begin
        pixel_src_s = i_Read_Data;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        if (i_Test_Pattern) begin
            pixel_src_s = bar_to_pixel(bar2_q);
        end else begin
            pixel_src_s = i_Read_Data;
        end
`endif
        if (vis_pipe_q[1]) begin
            pixel_d = pixel_src_s;
        end else begin
            pixel_d = {BITS_PER_PIXEL{1'b0}};
        end
    end

    // Raster counters, address register and the 3-stage aligned output pipeline
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            h_q           <= {HW{1'b0}};
            v_q           <= {VW{1'b0}};
            addr_cnt_q    <= {AW{1'b0}};
            rd_addr_q     <= {AW{1'b0}};
            vis_pipe_q    <= 2'b00;
            hs_pipe_q     <= 2'b00;
            vs_pipe_q     <= 2'b00;
            fs_pipe_q     <= 2'b00;
            pixel_q       <= {BITS_PER_PIXEL{1'b0}};
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            addr_cnt_q    <= addr_cnt_d;
            rd_addr_q     <= rd_addr_d;
            vis_pipe_q    <= {vis_pipe_q[0], vis_s};
            hs_pipe_q     <= {hs_pipe_q[0], hs_s};
            vs_pipe_q     <= {vs_pipe_q[0], vs_s};
            fs_pipe_q     <= {fs_pipe_q[0], fs_s};
            pixel_q       <= pixel_d;
            hsync_n_q     <= ~hs_pipe_q[1];
            vsync_n_q     <= ~vs_pipe_q[1];
            active_q      <= vis_pipe_q[1];
            frame_start_q <= fs_pipe_q[1];
        end
    end

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    // Colour-bar index follows the same two stages as the visible flag
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            bar1_q <= 3'd0;
            bar2_q <= 3'd0;
        end else begin
            bar1_q <= h_q[8:6];
            bar2_q <= bar1_q;
        end
    end
`endif

    assign o_Read_Addr   = rd_addr_q;
    assign o_Pixel       = pixel_q;
    assign o_HSync       = hsync_n_q;
    assign o_VSync       = vsync_n_q;
    assign o_Active      = active_q;
    assign o_Frame_Start = frame_start_q;

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter BITS_PER_PIXEL, default 3, pixel width read from the framebuffer.
REQ-002 SHALL have parameters H_VISIBLE/H_FRONT/H_SYNC/H_BACK, defaults 640/16/96/48, horizontal timing in clocks.
REQ-003 SHALL have parameters V_VISIBLE/V_FRONT/V_SYNC/V_BACK, defaults 480/10/2/33, vertical timing in lines.
REQ-004 SHALL have port i_Clock  input  1  pixel clock; the only clock.
REQ-005 SHALL have port i_Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port o_Read_Addr  output  $clog2(H_VISIBLE*V_VISIBLE-1)+1  framebuffer read address.
REQ-007 SHALL have port i_Read_Data  input  BITS_PER_PIXEL  framebuffer read data, valid one clock after the address.
REQ-008 SHALL have port o_Pixel  output  BITS_PER_PIXEL  pixel to the DAC, zero during blanking.
REQ-009 SHALL have port o_HSync  output  1  horizontal sync, active low.
REQ-010 SHALL have port o_VSync  output  1  vertical sync, active low.
REQ-011 SHALL have port o_Active  output  1  high while o_Pixel carries a visible pixel.
REQ-012 SHALL have port o_Frame_Start  output  1  one-clock pulse aligned with the first visible pixel of each frame.

Function
REQ-013 SHALL keep h counter 0..H_TOTAL-1 (H_TOTAL = sum of H params), incrementing every clock and wrapping to 0.
REQ-014 SHALL keep v counter 0..V_TOTAL-1, incrementing when h wraps; when h and v both wrap in the same clock, v SHALL go to 0.
REQ-015 SHALL treat h < H_VISIBLE && v < V_VISIBLE as visible; sync asserted when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (same form for v).
REQ-016 SHALL generate addresses with an incrementing linear counter (no multiplier): +1 per visible clock, cleared to 0 at h=0,v=0.
REQ-017 SHALL register o_Read_Addr one clock after the counter state; it SHALL hold its last value during blanking.
REQ-018 SHALL register o_Pixel from i_Read_Data; total latency counter state -> o_Pixel is 3 clocks.
REQ-019 SHALL delay o_HSync, o_VSync, o_Active and o_Frame_Start by the same 3 clocks so all outputs stay aligned.
REQ-020 SHALL force o_Pixel to 0 whenever the delayed visible flag is low.
REQ-021 SHALL present framebuffer word k at o_Pixel for visible pixel k (k = v*H_VISIBLE+h), last word H_VISIBLE*V_VISIBLE-1.

Reset
REQ-022 SHALL, while i_Reset is high at a clock edge, set h=0, v=0, address counter=0 and clear all delay-pipeline stages.
REQ-023 SHALL reset outputs to o_Read_Addr=0, o_Pixel=0, o_HSync=1, o_VSync=1, o_Active=0, o_Frame_Start=0.
REQ-024 SHALL, after reset deasserts mid-frame, restart at h=0,v=0; o_Frame_Start first pulses 3 clocks after the first non-reset clock.

Configuration
REQ-025 SHALL support macro VGA_SCANOUT_TEST_PATTERN_EN; when defined it SHALL add input i_Test_Pattern (1 bit).
REQ-026 SHALL, with the macro defined and i_Test_Pattern high, drive o_Pixel from the delayed h[8:6] (64-pixel colour bars, width-adjusted to BITS_PER_PIXEL) instead of i_Read_Data, with identical latency and blanking.
REQ-027 SHALL, without the macro, have no i_Test_Pattern port and always output framebuffer data.

Verification
REQ-028 SHALL verify line timing: free-run after reset -> o_HSync low exactly 96 clocks per 800-clock period, first falling edge 656+3 clocks after reset release.
REQ-029 SHALL verify frame timing: o_VSync low for exactly 1600 clocks per 420000-clock frame; o_Frame_Start pulses every 420000 clocks.
REQ-030 SHALL verify data alignment with a 1-clock-latency model RAM holding mem[k]=k mod 8 -> o_Pixel equals 0,1,2,... from the o_Frame_Start clock; o_Active high 640 clocks per line, 480 lines.
REQ-031 SHALL verify address range: o_Read_Addr sweeps 0..307199 once per frame, never exceeds 307199, holds value during blanking.
REQ-032 SHALL verify mid-frame reset: assert i_Reset at v=200,h=300 for 2 clocks -> outputs at reset values, next o_Frame_Start 3 clocks after release, o_Pixel=mem[0].
REQ-033 SHALL verify, with VGA_SCANOUT_TEST_PATTERN_EN and i_Test_Pattern=1 -> o_Pixel = 0 for h 0..63, 1 for 64..127, ... 7 for 448..511, 0 again from 512, and 0 in blanking.
